// File: rtl/y_upd_pkg.sv
// Shared definitions for the Y-bus diagonal update sequencer: FSM state
// encoding, datapath select codes and complex-word field positions.
package y_upd_pkg;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_WAIT_RD = 3'd2,
      ST_SUB     = 3'd3,
      ST_ADD     = 3'd4,
      ST_WB      = 3'd5
   } upd_state_e;

   // Operand select (calc_sel_old_or_new)
   localparam logic [1:0] SEL_NEW  = 2'b00;
   localparam logic [1:0] SEL_ZERO = 2'b01;
   localparam logic [1:0] SEL_OLD  = 2'b11;

   // Base select (calc_sel_diag_or_sum)
   localparam logic SEL_DIAG = 1'b0;
   localparam logic SEL_SUM  = 1'b1;

   // Arithmetic mode (calc_sel_mode_addsub)
   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   // Complex word layout: real part high, imaginary part low
   localparam int RE_MSB = 47;
   localparam int RE_LSB = 24;
   localparam int IM_MSB = 23;
   localparam int IM_LSB = 0;

   // Operand select to present while in state nxt, given the state we come from.
   // y_new is added exactly once: only on the cycle that enters ADD, because
   // the running sum feeds back and would otherwise accumulate y_new repeatedly.
   function automatic logic [1:0] operand_sel(input upd_state_e nxt, input upd_state_e cur);
      logic [1:0] sel;
      case (nxt)
         ST_SUB:  sel = SEL_OLD;
         ST_ADD:  sel = (cur == ST_SUB) ? SEL_NEW : SEL_ZERO;
         default: sel = SEL_ZERO;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/y_upd_wait_cnt.sv
// Loadable down-counter that times the datapath latency. Loading sets the
// count to CALC_LAT; it then counts down and stops at 1, where expired is high.
module y_upd_wait_cnt
   import y_upd_pkg::*;
#(
   parameter int CALC_LAT = 3
) (
   input  logic clock,
   input  logic reset,
   input  logic load,
   output logic expired
);

   localparam int CNT_W = $clog2(CALC_LAT + 1);

   logic [CNT_W-1:0] cnt_r;

   // Reload on phase entry, otherwise count down and park at 1
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_r <= CNT_W'(1);
      end else if (load) begin
         cnt_r <= CNT_W'(CALC_LAT);
      end else if (cnt_r > CNT_W'(1)) begin
         cnt_r <= cnt_r - CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign expired = (cnt_r == CNT_W'(1));

endmodule

// File: rtl/y_diag_update_seq.sv
// Y-bus diagonal update sequencer. Accepts an admittance change request,
// reads the bus diagonal, steers the external diagonal-calc datapath through
// subtract-y_old then add-y_new, and writes the new diagonal back.
// Optional build macro Y_DIAG_PAIR_EN: also update the diagonal of req_bus_b
// with the same y_old/y_new (skipped when req_bus_b equals req_bus).
module y_diag_update_seq
   import y_upd_pkg::*;
#(
   parameter int WIDTH    = 48,
   parameter int ADDR_W   = 10,
   parameter int CALC_LAT = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_bus,
   input  logic [ADDR_W-1:0] req_bus_b,
   input  logic [WIDTH-1:0]  req_y_old,
   input  logic [WIDTH-1:0]  req_y_new,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [WIDTH-1:0]  mem_rdata,
   output logic              mem_wr_en,
   output logic [WIDTH-1:0]  mem_wdata,
   output logic [WIDTH-1:0]  calc_y_diag,
   output logic [WIDTH-1:0]  calc_y_old,
   output logic [WIDTH-1:0]  calc_y_new,
   output logic [1:0]        calc_sel_old_or_new,
   output logic              calc_sel_diag_or_sum,
   output logic              calc_sel_mode_addsub,
   input  logic [WIDTH-1:0]  calc_y_new_diag,
   output logic              busy,
   output logic              done
);

   upd_state_e        state_r;
   upd_state_e        state_s;
   logic [ADDR_W-1:0] bus_r;
   logic [ADDR_W-1:0] bus_s;
   logic              accept_s;
   logic              load_s;
   logic              cnt_expired_s;

   // Next values of the registered control outputs
   logic              rd_en_s;
   logic              wr_en_s;
   logic [ADDR_W-1:0] addr_s;
   logic [1:0]        sel_on_s;
   logic              sel_ds_s;
   logic              mode_s;
   logic              ready_s;

   logic              rd_en_r;
   logic              wr_en_r;
   logic [ADDR_W-1:0] addr_r;
   logic [1:0]        sel_on_r;
   logic              sel_ds_r;
   logic              mode_r;
   logic              ready_r;
   logic              busy_r;
   logic [WIDTH-1:0]  y_diag_r;
   logic [WIDTH-1:0]  y_old_r;
   logic [WIDTH-1:0]  y_new_r;

`ifdef Y_DIAG_PAIR_EN
   logic [ADDR_W-1:0] bus_b_r;
   logic              second_r;
   logic              second_set_s;
`else
   logic              unused_bus_b_s;
   assign unused_bus_b_s = ^req_bus_b;
`endif

   y_upd_wait_cnt #(
      .CALC_LAT (CALC_LAT)
   ) u_wait_cnt (
      .clock   (clock),
      .reset   (reset),
      .load    (load_s),
      .expired (cnt_expired_s)
   );

   // Next-state logic: request handshake, phase timing and pass sequencing
   always_comb begin
      state_s  = state_r;
      bus_s    = bus_r;
      accept_s = 1'b0;
      load_s   = 1'b0;
`ifdef Y_DIAG_PAIR_EN
      second_set_s = 1'b0;
`endif
      case (state_r)
         ST_IDLE: begin
            if (req_valid && ready_r) begin
               state_s  = ST_FETCH;
               bus_s    = req_bus;
               accept_s = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_FETCH: begin
            state_s = ST_WAIT_RD;
         end
         ST_WAIT_RD: begin
            state_s = ST_SUB;
            load_s  = 1'b1;
         end
         ST_SUB: begin
            if (cnt_expired_s) begin
               state_s = ST_ADD;
               load_s  = 1'b1;
            end else begin
               state_s = ST_SUB;
            end
         end
         ST_ADD: begin
            if (cnt_expired_s) begin
               state_s = ST_WB;
            end else begin
               state_s = ST_ADD;
            end
         end
         ST_WB: begin
`ifdef Y_DIAG_PAIR_EN
            if (!second_r && (bus_b_r != bus_r)) begin
               state_s      = ST_FETCH;
               bus_s        = bus_b_r;
               second_set_s = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
`else
            state_s = ST_IDLE;
`endif
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Control outputs are decoded from the next state so that, once
   // registered, they line up with the cycle the FSM spends in that state
   always_comb begin
      rd_en_s  = (state_s == ST_FETCH);
      wr_en_s  = (state_s == ST_WB);
      addr_s   = (rd_en_s || wr_en_s) ? bus_s : {ADDR_W{1'b0}};
      sel_on_s = operand_sel(state_s, state_r);
      sel_ds_s = (state_s == ST_ADD) ? SEL_SUM : SEL_DIAG;
      mode_s   = (state_s == ST_SUB) ? MODE_SUB : MODE_ADD;
      ready_s  = (state_s == ST_IDLE);
   end

   // State and current-bus registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
         bus_r   <= {ADDR_W{1'b0}};
      end else begin
         state_r <= state_s;
         bus_r   <= bus_s;
      end
   end

`ifdef Y_DIAG_PAIR_EN
   // Second-bus index and pass tracking for paired updates
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bus_b_r  <= {ADDR_W{1'b0}};
         second_r <= 1'b0;
      end else if (accept_s) begin
         bus_b_r  <= req_bus_b;
         second_r <= 1'b0;
      end else if (second_set_s) begin
         bus_b_r  <= bus_b_r;
         second_r <= 1'b1;
      end else begin
         bus_b_r  <= bus_b_r;
         second_r <= second_r;
      end
   end
`endif

   // Datapath operands: y_old/y_new at accept, diagonal when read data returns
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         y_old_r  <= {WIDTH{1'b0}};
         y_new_r  <= {WIDTH{1'b0}};
         y_diag_r <= {WIDTH{1'b0}};
      end else begin
         if (accept_s) begin
            y_old_r <= req_y_old;
            y_new_r <= req_y_new;
         end else begin
            y_old_r <= y_old_r;
            y_new_r <= y_new_r;
         end
         if (state_r == ST_WAIT_RD) begin
            y_diag_r <= mem_rdata;
         end else begin
            y_diag_r <= y_diag_r;
         end
      end
   end

   // Registered control outputs; reset aborts any pending write immediately
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_en_r  <= 1'b0;
         wr_en_r  <= 1'b0;
         addr_r   <= {ADDR_W{1'b0}};
         sel_on_r <= SEL_ZERO;
         sel_ds_r <= SEL_DIAG;
         mode_r   <= MODE_ADD;
         ready_r  <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         rd_en_r  <= rd_en_s;
         wr_en_r  <= wr_en_s;
         addr_r   <= addr_s;
         sel_on_r <= sel_on_s;
         sel_ds_r <= sel_ds_s;
         mode_r   <= mode_s;
         ready_r  <= ready_s;
         busy_r   <= !ready_s;
      end
   end

   assign req_ready            = ready_r;
   assign busy                 = busy_r;
   assign mem_rd_en            = rd_en_r;
   assign mem_wr_en            = wr_en_r;
   assign done                 = wr_en_r;
   assign mem_addr             = addr_r;
   assign calc_y_diag          = y_diag_r;
   assign calc_y_old           = y_old_r;
   assign calc_y_new           = y_new_r;
   assign calc_sel_old_or_new  = sel_on_r;
   assign calc_sel_diag_or_sum = sel_ds_r;
   assign calc_sel_mode_addsub = mode_r;
   // The datapath result settles in the WB cycle itself, so it is forwarded
   // directly, gated by the registered write strobe
   assign mem_wdata            = wr_en_r ? calc_y_new_diag : {WIDTH{1'b0}};

endmodule
